serial_chunk_adder: RTL
=======================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of 4 and >= 8.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port in_valid  input  1  upstream asserts when a, b, cin are valid.
REQ-005 Port in_ready  output  1  block can accept an operand set.
REQ-006 Port a  input  WIDTH  first operand, unsigned.
REQ-007 Port b  input  WIDTH  second operand, unsigned.
REQ-008 Port cin  input  1  carry into bit 0.
REQ-009 Port out_valid  output  1  sum and cout are valid.
REQ-010 Port out_ready  input  1  downstream accepts the result.
REQ-011 Port sum  output  WIDTH  registered a+b+cin modulo 2^WIDTH.
REQ-012 Port cout  output  1  registered carry out of bit WIDTH-1.
REQ-013 Port busy  output  1  high in states RUN and DONE.

Function
REQ-014 Derived constant NCHUNK = WIDTH/4; chunk index register width = $clog2(NCHUNK).
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b into operand registers, cin into carry register, clear index to 0, clear sum register, go RUN.
REQ-017 RUN: each cycle add 4-bit slice [4*idx+3:4*idx] of captured a and b plus carry register; write 4-bit result into the same slice of sum; write slice carry-out into carry register; increment idx.
REQ-018 RUN -> DONE on the cycle idx==NCHUNK-1 is processed; cout takes that slice's carry-out on the same edge.
REQ-019 out_valid SHALL rise exactly NCHUNK rising edges after the accepting edge (4 for WIDTH=16).
REQ-020 DONE: out_valid=1; sum and cout held stable until out_valid&&out_ready; on that handshake go IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored and no operand register changes.
REQ-022 Captured operands SHALL be insensitive to a, b, cin changes after the accepting edge.
REQ-023 out_ready high while not in DONE has no effect; out_ready held high in DONE completes in one cycle.
REQ-024 Throughput: one operation per NCHUNK+2 cycles minimum; no overlap of consecutive operations.
REQ-025 sum/cout after handshake SHALL hold last value until next operation clears sum at accept.

Reset
REQ-026 rst_n low at any time, including mid-RUN or in DONE, SHALL immediately force state IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
REQ-027 The first accept is possible on the first rising edge with rst_n high; no partial operation survives reset.

Structure
REQ-028 Package chunk_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and constant CHUNK_W=4.
REQ-029 One sub-module: the existing carry_lookahead_adder with N=4, instantiated once, fed the current slices and carry register; its result[4] is the slice carry-out.
REQ-030 Datapath registers and FSM SHALL live in this module; no other sub-modules.

Verification
REQ-031 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, out_valid 4 edges after accept.
REQ-032 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
REQ-033 a=16'h8000, b=16'h8000, cin=0, out_ready low 5 cycles in DONE -> sum=16'h0000, cout=1 held, out_valid held 5 cycles, IDLE one edge after out_ready high.
REQ-034 rst_n pulsed low after 2 RUN cycles -> all outputs 0, in_ready=1 immediately; new a=16'h0003, b=16'h0004 -> sum=16'h0007.
REQ-035 in_valid held high with changing a, b during RUN -> in_ready=0, result matches first captured operands only.
REQ-036 1000 random a, b, cin with random out_ready stalls -> {cout,sum} == a+b+cin every transaction.

Source files
------------

// File: rtl/chunk_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encoding and chunk width.
package chunk_adder_pkg;
   localparam int CHUNK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder; result[N] is the carry out of the top bit.
module carry_lookahead_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N:0]   result
);
   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         term_c;
   logic         term_p;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is the flattened generate/propagate sum, not a ripple chain.
   always_comb begin
      c      = '0;
      c[0]   = cin;
      term_c = 1'b0;
      term_p = 1'b0;
      for (int i = 0; i < N; i++) begin
         term_c = g[i];
         term_p = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            term_c = term_c | (term_p & g[j]);
            term_p = term_p & p[j];
         end
         c[i+1] = term_c | (term_p & cin);
      end
   end

   assign result = {c[N], p ^ c[N-1:0]};
endmodule

// File: rtl/serial_chunk_adder.sv
// Adds two WIDTH-bit operands one 4-bit chunk per cycle through a shared CLA,
// with valid/ready handshakes on both the operand and result sides.
module serial_chunk_adder
   import chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK_W;
   localparam int IDX_W  = $clog2(NCHUNK);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;

   logic [CHUNK_W-1:0] a_chunks [NCHUNK];
   logic [CHUNK_W-1:0] b_chunks [NCHUNK];
   logic [CHUNK_W-1:0] a_slice;
   logic [CHUNK_W-1:0] b_slice;
   logic [CHUNK_W:0]   slice_res;
   logic               accept;
   logic               out_hs;
   logic               last_chunk;

   genvar gi;
   generate
      for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign a_chunks[gi] = a_q[gi*CHUNK_W +: CHUNK_W];
         assign b_chunks[gi] = b_q[gi*CHUNK_W +: CHUNK_W];
      end
   endgenerate

   assign a_slice    = a_chunks[idx_q];
   assign b_slice    = b_chunks[idx_q];
   assign accept     = in_valid && (state_q == IDLE);
   assign out_hs     = out_ready && (state_q == DONE);
   assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

   carry_lookahead_adder #(
      .N(CHUNK_W)
   ) u_cla (
      .a      (a_slice),
      .b      (b_slice),
      .cin    (carry_q),
      .result (slice_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)     state_d = RUN;
         RUN:     if (last_chunk) state_d = DONE;
         DONE:    if (out_hs)     state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
   end

   // Operands only load on accept, so later input changes cannot leak in.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         idx_d   = '0;
         sum_d   = '0;
      end else if (state_q == RUN) begin
         sum_d[CHUNK_W*idx_q +: CHUNK_W] = slice_res[CHUNK_W-1:0];
         carry_d = slice_res[CHUNK_W];
         idx_d   = idx_q + 1'b1;
         if (last_chunk) begin
            cout_d = slice_res[CHUNK_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
endmodule
